uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
- Parametrised UART receiver; successor to the fixed 8N1 / 9600-baud / 50 MHz receiver.
- Adds configurable data width, parity, stop bits and baud divisor.
- Adds an input synchroniser, false-start rejection, framing/parity/overrun detection, break handling and a valid/ready output handshake.
- Sits between the board RX pin and a downstream FIFO or command parser.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in baud. Derived CLKS_PER_BIT = CLK_FREQ/BAUD (integer division); HALF_BIT = CLKS_PER_BIT/2.
- DATA_BITS, 8, payload width; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- system_clock  in  1  clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_d_in  in  1  asynchronous serial line; idles high.
- rx_data  out  DATA_BITS  received payload, LSB first on the line.
- rx_valid  out  1  rx_data and error flags are valid.
- rx_ready  in  1  consumer accepts the beat when rx_valid && rx_ready.
- frame_err  out  1  with the beat: a stop bit was sampled low.
- parity_err  out  1  with the beat: parity mismatch; always 0 when PARITY = 0.
- overrun_err  out  1  single-cycle pulse: a completed frame was dropped.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (system_clock); reset is synchronous and active-high.
- Reset values: rx_data = 0, rx_valid = 0, frame_err = 0, parity_err = 0, overrun_err = 0, busy = 0, FSM = IDLE, synchroniser flops = 1, bit counter = 0, baud counter = 0.
- Reset mid-frame aborts the frame with no beat delivered.
- Synchroniser: rx_d_in passes through 2 flops. All decisions use the synchronised signal rxs. This adds 2 cycles of latency.
- Baud counter:
  - Reloads to 0 on entry to each state.
  - START waits HALF_BIT - 1 counts.
  - DATA, PARITY and STOP sample when the counter reaches CLKS_PER_BIT - 1, then reload.
  - The counter must not run free in IDLE.
- FSM states and transitions:
  - IDLE: rxs == 0 moves to START.
  - START: at the mid-bit point, rxs == 0 moves to DATA. rxs == 1 is a false start: return to IDLE, no beat, no error.
  - DATA: shifts in DATA_BITS samples, LSB first. After the last sample, go to PARITY if PARITY != 0, else STOP.
  - PARITY: sample the parity bit. Odd mode: error if XOR(data, parity bit) == 0. Even mode: error if the XOR == 1.
  - STOP: sample STOP_BITS bits. frame_err = 1 if any stop sample is 0. After the last stop sample:
    - Stop samples all 1: go to IDLE.
    - Any stop sample 0: go to BREAK_WAIT.
  - BREAK_WAIT: stay until rxs == 1, then go to IDLE. This covers a break (line held low) and prevents re-triggering on it.
- Beat delivery: in the cycle after the last stop sample, the frame outcome is:
  - rx_valid = 0, or rx_valid && rx_ready in that same cycle: load rx_data, frame_err and parity_err, and assert rx_valid.
  - rx_valid = 1 and rx_ready = 0: keep the old beat unchanged, drop the new frame, pulse overrun_err for 1 cycle.
- A frame with frame_err or parity_err is still delivered, with its flags set.
- Handshake:
  - rx_valid stays high, and rx_data and the flags stay stable, until rx_valid && rx_ready.
  - rx_valid then drops on the next edge unless a new beat loads in that same cycle.
- End-to-end latency: rx_valid rises 1 cycle after the final stop-bit sample point (plus the 2-cycle synchroniser).
- Back-to-back frames: a new start edge is accepted from the first IDLE cycle after STOP. No dead time is required beyond the stop bit(s).

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each data, parity and stop sample is the 2-of-3 majority of rxs at counts (sample point - 1, sample point, sample point + 1).
  - The START check uses the same vote, centred on HALF_BIT - 1.
  - Requires CLKS_PER_BIT >= 4.
- Undefined: a single sample at the sample point; the voting logic is absent.

Test Plan (CLK_FREQ = 1000000, BAUD = 100000, i.e. 10 clocks per bit, unless noted):
- 8N1, send 0xA5 with rx_ready = 1 -> one rx_valid cycle, rx_data = 0xA5, frame_err = 0, parity_err = 0, overrun_err = 0; busy falls within 1 cycle of the stop sample.
- PARITY = 2, DATA_BITS = 7, send 0x41 with parity bit 1 -> rx_data = 0x41, parity_err = 1; resend with parity bit 0 -> parity_err = 0.
- STOP_BITS = 2, send 0x3C with the second stop bit 0, then hold the line low for 30 bits -> beat with rx_data = 0x3C, frame_err = 1; no further beats until the line returns high; the next frame 0x55 is received cleanly.
- Glitch: 3-cycle low pulse on an idle line -> no rx_valid, busy returns to 0, no error flags.
- Overrun: rx_ready = 0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun_err pulses once; raise rx_ready -> 0x11 consumed and rx_valid drops.
- Reset asserted mid-DATA of 0xFF, then released, then 0x0F sent -> outputs zero during reset, no partial beat, then one beat with rx_data = 0x0F.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param - parameterised UART receiver.
//
// Receives asynchronous serial frames (start, DATA_BITS payload LSB first,
// optional odd/even parity, STOP_BITS stop bits) and presents each frame as
// a valid/ready beat with framing and parity flags. It sits between the
// board RX pin and a downstream FIFO or command parser.
//
// Parameters:
//   CLK_FREQ   system clock in Hz
//   BAUD       line rate; CLKS_PER_BIT = CLK_FREQ/BAUD, HALF_BIT = CLKS_PER_BIT/2
//   DATA_BITS  payload width, 5..9
//   PARITY     0 none, 1 odd, 2 even
//   STOP_BITS  1 or 2
//
// Ports:
//   system_clock  in   clock, rising edge
//   reset         in   synchronous active-high reset
//   rx_d_in       in   async serial line, idles high
//   rx_data       out  received payload
//   rx_valid      out  rx_data / frame_err / parity_err valid
//   rx_ready      in   consumer accepts beat when rx_valid && rx_ready
//   frame_err     out  with the beat: a stop bit sampled low
//   parity_err    out  with the beat: parity mismatch
//   overrun_err   out  one-cycle pulse: a completed frame was dropped
//   busy          out  FSM not in IDLE
//
// Optional feature (macro UART_RX_MAJORITY_EN): each START/data/parity/stop
// decision is a 2-of-3 vote of rxs around the sample point. Needs
// CLKS_PER_BIT >= 4. Without the macro a single sample is taken.

module uart_rx_param #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 system_clock,
  input  logic                 reset,
  input  logic                 rx_d_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1, rxs;
  logic [CW-1:0]          cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   stop_bad, par_bad;
  logic                   bit_s;      // the value used for a bit decision
  logic                   tick;       // bit decision taken this cycle
  logic                   last_data, last_stop;
  logic                   frame_done, load;

`ifdef UART_RX_MAJORITY_EN
  // The vote needs the sample after the centre, so every decision is taken
  // one count later than the centre; bit spacing is unchanged.
  localparam int LAG = 1;
  logic rxs_d1, rxs_d2;

  always_ff @(posedge system_clock) begin
    if (reset) begin
      rxs_d1 <= 1'b1;
      rxs_d2 <= 1'b1;
    end else begin
      rxs_d1 <= rxs;
      rxs_d2 <= rxs_d1;
    end
  end

  assign bit_s = (rxs & rxs_d1) | (rxs & rxs_d2) | (rxs_d1 & rxs_d2);
`else
  localparam int LAG = 0;
  assign bit_s = rxs;
`endif

  localparam int START_PT = HALF_BIT - 1 + LAG;
  localparam int BIT_PT   = CLKS_PER_BIT - 1;

  assign busy = (state_q != S_IDLE);

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    tick      = 1'b0;
    last_data = (bit_cnt == 4'(DATA_BITS - 1));
    last_stop = (bit_cnt == 4'(STOP_BITS - 1));
    unique case (state_q)
      S_IDLE:   if (!rxs) state_d = S_START;
      S_START:  if (cnt == CW'(START_PT)) begin
                  tick    = 1'b1;
                  // line back high at mid-start: false start, no beat
                  state_d = bit_s ? S_IDLE : S_DATA;
                end
      S_DATA:   if (cnt == CW'(BIT_PT)) begin
                  tick = 1'b1;
                  if (last_data) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                end
      S_PARITY: if (cnt == CW'(BIT_PT)) begin
                  tick    = 1'b1;
                  state_d = S_STOP;
                end
      S_STOP:   if (cnt == CW'(BIT_PT)) begin
                  tick = 1'b1;
                  // a low stop bit may be a break; wait for the line to rise
                  // so the held-low line is not taken as a new start
                  if (last_stop) state_d = (stop_bad || !bit_s) ? S_BREAK : S_IDLE;
                end
      S_BREAK:  if (rxs) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign frame_done = (state_q == S_STOP) && tick && last_stop;
  // deliver when the output slot is empty or being emptied this cycle
  assign load       = frame_done && (!rx_valid || rx_ready);

  // State register, synchroniser, counters
  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      sync1   <= 1'b1;
      rxs     <= 1'b1;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      state_q <= state_d;
      sync1   <= rx_d_in;
      rxs     <= sync1;
      if (state_d != state_q || tick || state_q == S_IDLE || state_q == S_BREAK)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state_d != state_q) bit_cnt <= '0;
      else if (tick)          bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Frame datapath and output beat
  always_ff @(posedge system_clock) begin
    if (reset) begin
      shift       <= '0;
      stop_bad    <= 1'b0;
      par_bad     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (state_q == S_IDLE) begin
        stop_bad <= 1'b0;
        par_bad  <= 1'b0;
      end
      if (state_q == S_DATA && tick)
        shift <= {bit_s, shift[DATA_BITS-1:1]};
      // odd: error when XOR of data and parity bit is 0; even: when it is 1
      if (state_q == S_PARITY && tick)
        par_bad <= (PARITY == 1) ? ~(^shift ^ bit_s) : (^shift ^ bit_s);
      if (state_q == S_STOP && tick && !bit_s)
        stop_bad <= 1'b1;

      overrun_err <= frame_done && rx_valid && !rx_ready;

      if (load) begin
        rx_data    <= shift;
        rx_valid   <= 1'b1;
        frame_err  <= stop_bad | ~bit_s;
        parity_err <= par_bad;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
